// File: rtl/gb_lcd_pixel_tx.sv
// GameBoy LCD pixel transmitter: serializes 2bpp tile rows through the BGP palette
// into the LD/PX_VALID stream while sequencing OAM/XFER/HBLANK/VBLANK dot timing.
module gb_lcd_pixel_tx #(
    parameter int H_PIXELS    = 160,
    parameter int V_LINES     = 144,
    parameter int LINE_DOTS   = 456,
    parameter int TOTAL_LINES = 154,
    parameter int OAM_DOTS    = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       lcd_on,
    input  logic [7:0] bgp,
    input  logic [7:0] tile_lo,
    input  logic [7:0] tile_hi,
    input  logic       tile_valid,
    output logic       tile_ready,
    output logic [1:0] LD,
    output logic       PX_VALID,
    output logic [7:0] LX,
    output logic [7:0] LY,
    output logic [1:0] MODE,
    output logic       VBLANK_PULSE,
    output logic       UNDERRUN
);

    typedef enum logic [1:0] {
        HBLANK = 2'd0,
        VBLANK = 2'd1,
        OAM    = 2'd2,
        XFER   = 2'd3
    } mode_t;

    localparam logic [8:0] DOT_LAST = 9'(LINE_DOTS - 1);
    localparam logic [8:0] DOT_XFER = 9'(OAM_DOTS);
    localparam logic [7:0] LY_LAST  = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] LY_VIS   = 8'(V_LINES);
    localparam logic [7:0] LX_END   = 8'(H_PIXELS);
    localparam logic [7:0] LX_LAST  = 8'(H_PIXELS - 1);

    mode_t      state, state_n;
    logic [8:0] dot, dot_n;
    logic [7:0] ly, ly_n;
    logic [7:0] lx;
    logic [3:0] cnt;
    logic [7:0] lo_sr, hi_sr;
    logic       line_end, emit, last_px, load, underrun_c;
    logic [1:0] idx;

    always_comb begin
        line_end   = ce && (dot == DOT_LAST);
        emit       = ce && (state == XFER) && (cnt != 4'd0);
        last_px    = emit && (lx == LX_LAST);
        tile_ready = lcd_on && !reset && (state == XFER) && (cnt == 4'd0) && (lx < LX_END);
        load       = tile_valid && tile_ready;
        // A line that finishes its last pixel on the final dot is complete, not starved.
        underrun_c = line_end && (state == XFER) && !last_px;
        idx        = {hi_sr[7], lo_sr[7]};

        dot_n = dot;
        if (ce) dot_n = line_end ? 9'd0 : dot + 9'd1;
        ly_n = ly;
        if (line_end) ly_n = (ly == LY_LAST) ? 8'd0 : ly + 8'd1;

        state_n = state;
        if (ly_n >= LY_VIS)         state_n = VBLANK;
        else if (dot_n < DOT_XFER)  state_n = OAM;
        else if (dot_n == DOT_XFER) state_n = XFER;
        else if (last_px)           state_n = HBLANK;
    end

    always_ff @(posedge clk) begin
        if (reset || !lcd_on) begin
            state        <= HBLANK;
            dot          <= 9'd0;
            ly           <= 8'd0;
            lx           <= 8'd0;
            cnt          <= 4'd0;
            lo_sr        <= 8'd0;
            hi_sr        <= 8'd0;
            LD           <= 2'd0;
            PX_VALID     <= 1'b0;
            VBLANK_PULSE <= 1'b0;
            UNDERRUN     <= 1'b0;
        end else begin
            state        <= state_n;
            dot          <= dot_n;
            ly           <= ly_n;
            PX_VALID     <= emit;
            VBLANK_PULSE <= line_end && (ly_n == LY_VIS);
            UNDERRUN     <= underrun_c;

            if (line_end)  lx <= 8'd0;
            else if (emit) lx <= lx + 8'd1;

            if (underrun_c)  cnt <= 4'd0;
            else if (load)   cnt <= 4'd8;
            else if (emit)   cnt <= cnt - 4'd1;

            // load and emit are exclusive: load needs cnt==0, emit needs cnt>0
            if (load) begin
                lo_sr <= tile_lo;
                hi_sr <= tile_hi;
            end else if (emit) begin
                LD    <= bgp[{idx, 1'b1} -: 2];
                lo_sr <= {lo_sr[6:0], 1'b0};
                hi_sr <= {hi_sr[6:0], 1'b0};
            end
        end
    end

    assign LX   = lx;
    assign LY   = ly;
    assign MODE = state;

endmodule

// File: tb/tb_gb_lcd_pixel_tx.sv
// Bench for gb_lcd_pixel_tx: scoreboarded pixel stream over one frame (with a starved
// line 5), then a half-rate ce run interrupted by lcd_on dropping mid-XFER.
module tb_gb_lcd_pixel_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b1;
    logic       lcd_on = 1'b1;
    logic [7:0] bgp = 8'hE4;
    logic [7:0] tile_lo = 8'h00;
    logic [7:0] tile_hi = 8'h00;
    logic       tile_valid = 1'b0;
    logic       tile_ready;
    logic [1:0] LD;
    logic       PX_VALID;
    logic [7:0] LX;
    logic [7:0] LY;
    logic [1:0] MODE;
    logic       VBLANK_PULSE;
    logic       UNDERRUN;

    gb_lcd_pixel_tx dut (
        .clk(clk), .reset(reset), .ce(ce), .lcd_on(lcd_on), .bgp(bgp),
        .tile_lo(tile_lo), .tile_hi(tile_hi), .tile_valid(tile_valid),
        .tile_ready(tile_ready), .LD(LD), .PX_VALID(PX_VALID), .LX(LX), .LY(LY),
        .MODE(MODE), .VBLANK_PULSE(VBLANK_PULSE), .UNDERRUN(UNDERRUN)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [1:0] sb_q[$];
    int m_dot = 0, m_ly = 0;
    int px_line = 0, hs_line = 0, frame_px = 0, vb_count = 0;
    int starve_line = 5;
    bit exp_ur = 0, exp_vb = 0;
    bit checking = 0, feed = 0, half_rate = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] colour(input logic [7:0] pal, input logic [1:0] i);
        case (i)
            2'd0:    return pal[1:0];
            2'd1:    return pal[3:2];
            2'd2:    return pal[5:4];
            default: return pal[7:6];
        endcase
    endfunction

    // Dot/line reference model plus scoreboard push on each accepted tile row.
    always @(posedge clk) begin
        if (reset || !lcd_on) begin
            m_dot = 0; m_ly = 0; exp_ur = 0; exp_vb = 0;
            px_line = 0; hs_line = 0;
            sb_q.delete();
        end else begin
            if (tile_valid && tile_ready) begin
                for (int i = 0; i < 8; i++)
                    sb_q.push_back(colour(bgp, {tile_hi[7-i], tile_lo[7-i]}));
                hs_line++;
            end
            exp_ur = ce && m_dot == 455 && m_ly == starve_line;
            exp_vb = ce && m_dot == 455 && m_ly == 143;
            if (ce) begin
                if (m_dot == 455) begin
                    m_dot = 0;
                    m_ly = (m_ly == 153) ? 0 : m_ly + 1;
                    px_line = 0; hs_line = 0;
                end else m_dot++;
            end
        end
    end

    // Tile source: line 0 solid colour 1, line 1 the AA/CC ramp, later lines random.
    always @(negedge clk) begin
        ce = half_rate ? ~ce : 1'b1;
        if (m_ly == 0) begin
            tile_lo = 8'hFF; tile_hi = 8'h00; bgp = 8'hE4;
        end else if (m_ly == 1) begin
            tile_lo = 8'hAA; tile_hi = 8'hCC; bgp = 8'h1B;
        end else begin
            tile_lo = 8'($urandom); tile_hi = 8'($urandom); bgp = 8'(m_ly * 59);
        end
        tile_valid = feed && !(m_ly == starve_line && hs_line >= 10);
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("underrun", UNDERRUN, exp_ur);
            chk("vblank_pulse", VBLANK_PULSE, exp_vb);
            if (VBLANK_PULSE) vb_count++;
            if (m_ly < 144) begin
                if (m_dot == 79) chk("mode_oam", MODE, 2);
                if (m_dot == 80) chk("mode_xfer", MODE, 3);
                if (m_dot == 455) begin
                    chk("mode_line_end", MODE, (m_ly == starve_line) ? 3 : 0);
                    chk("px_per_line", px_line, (m_ly == starve_line) ? 80 : 160);
                    chk("tiles_per_line", hs_line, (m_ly == starve_line) ? 10 : 20);
                end
            end else if (m_dot == 200) chk("mode_vblank", MODE, 1);
            if (m_dot == 200) chk("ly", LY, m_ly);
        end
        if (PX_VALID) begin
            px_line++;
            frame_px++;
            vectors++;
            assert (sb_q.size() > 0) else begin
                miscompares++;
                $error("FAIL sb_underflow: observed pixel with %0d queued, expected >0", sb_q.size());
            end
            if (sb_q.size() > 0) chk("ld", LD, sb_q.pop_front());
            chk("lx", LX, px_line);
            if (checking) chk("mode_px", MODE, (px_line == 160) ? 0 : 3);
        end
    end

    task automatic wait_ly(input int ly, input int budget, input string tag);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = (m_ly == ly);
        end
        chk(tag, hit, 1);
    endtask

    initial begin
        bit hit;
        // reset held two clocks: everything quiet
        repeat (2) @(negedge clk);
        chk("rst_ld", LD, 0);
        chk("rst_px_valid", PX_VALID, 0);
        chk("rst_tile_ready", tile_ready, 0);
        chk("rst_lx", LX, 0);
        chk("rst_ly", LY, 0);
        chk("rst_mode", MODE, 0);

        // one full frame, line 5 starved after 10 tiles
        feed = 1; reset = 0; checking = 1;
        wait_ly(153, 80000, "reach_ly153");
        wait_ly(0, 1000, "ly_wrap");
        chk("ly_wrapped", LY, 0);
        chk("frame_px", frame_px, 143 * 160 + 80);
        chk("vblank_pulses", vb_count, 1);
        chk("mode_new_frame", MODE, 2);
        checking = 0;
        starve_line = -1;

        // half-rate ce, drop lcd_on at LX=37
        half_rate = 1;
        hit = 0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            hit = (LX == 8'd37);
        end
        chk("reach_lx37", hit, 1);
        lcd_on = 0;
        @(negedge clk);
        chk("off_ld", LD, 0);
        chk("off_px_valid", PX_VALID, 0);
        chk("off_tile_ready", tile_ready, 0);
        chk("off_lx", LX, 0);
        chk("off_ly", LY, 0);
        chk("off_mode", MODE, 0);
        repeat (3) @(negedge clk);
        lcd_on = 1;
        repeat (4) @(negedge clk);
        chk("reen_ly", LY, 0);
        chk("reen_mode", MODE, 2);
        hit = 0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk);
            hit = PX_VALID;
        end
        chk("reen_first_px", hit, 1);
        // first pixel emitted during dot 80, so the dot counter reads 81 alongside it
        chk("reen_px_dot", m_dot, 81);
        chk("reen_px_lx", LX, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
